// File: rtl/shift_mix_stage.sv
// AES ShiftRows + MixColumns stage behind a valid/ready output register.
// Define SHIFT_MIX_SKID_EN for a two-entry skid buffer with a registered in_ready.
module shift_mix_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ip,
    input  logic         last_round,
    input  logic         enable,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] op,
    output logic         out_last
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_xform;
    logic         w_in_fire;

    // Byte k sits at ip[127-8k -: 8]; byte 4c+r = s(r,c), and s'(r,c) takes s(r,(c+r)%4).
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shift_rows
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
            assign w_sr[127-8*gi -: 8] = ip[127-8*SRC -: 8];
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_mix_cols
            logic [7:0] w_a, w_b, w_c, w_d;
            assign w_a = w_sr[127-32*gi -: 8];
            assign w_b = w_sr[119-32*gi -: 8];
            assign w_c = w_sr[111-32*gi -: 8];
            assign w_d = w_sr[103-32*gi -: 8];
            assign w_mc[127-32*gi -: 8] = xtime(w_a) ^ xtime(w_b) ^ w_b ^ w_c ^ w_d;
            assign w_mc[119-32*gi -: 8] = w_a ^ xtime(w_b) ^ xtime(w_c) ^ w_c ^ w_d;
            assign w_mc[111-32*gi -: 8] = w_a ^ w_b ^ xtime(w_c) ^ xtime(w_d) ^ w_d;
            assign w_mc[103-32*gi -: 8] = xtime(w_a) ^ w_a ^ w_b ^ w_c ^ xtime(w_d);
        end
    endgenerate

    assign w_xform   = !enable ? ip : (last_round ? w_sr : w_mc);
    assign w_in_fire = in_valid && in_ready;

    logic [127:0] r_op;
    logic         r_last;
    logic         r_valid;

    assign out_valid = r_valid;
    assign op        = r_op;
    assign out_last  = r_last;

`ifdef SHIFT_MIX_SKID_EN
    logic [127:0] r_skid_op;
    logic         r_skid_last;
    logic         r_skid_valid;
    logic         w_out_fire;

    assign w_out_fire = r_valid && out_ready;
    // Gated by rst_n so the port reads 0 throughout reset and 1 right after release.
    assign in_ready   = rst_n && !r_skid_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_op         <= 128'h0;
            r_last       <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_op    <= 128'h0;
            r_skid_last  <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_out_fire) begin
                r_op         <= r_skid_op;
                r_last       <= r_skid_last;
                r_skid_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_valid || w_out_fire) begin
                r_valid <= 1'b1;
                r_op    <= w_xform;
                r_last  <= last_round;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_op    <= w_xform;
                r_skid_last  <= last_round;
            end
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end
`else
    assign in_ready = rst_n && (!r_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_op    <= 128'h0;
            r_last  <= 1'b0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_op    <= w_xform;
            r_last  <= last_round;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_shift_mix_stage.sv
// Scoreboard bench for shift_mix_stage: directed FIPS-197 vectors, stalls, reset and random streams.
module tb_shift_mix_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ip;
    logic         last_round;
    logic         enable;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] op;
    logic         out_last;

    always #5 clk = ~clk;

    shift_mix_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ip         (ip),
        .last_round (last_round),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op         (op),
        .out_last   (out_last)
    );

`ifdef SHIFT_MIX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_MC  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] COL_IN   = 128'hdb000000001300000000530000000045;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc000000000000000000000000;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [127:0] op;
        logic         last;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Reference model: generic GF(2^8) multiply and matrix form of AES round steps.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] d, input logic en, input logic lr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] m [4][4];
        logic [7:0] coef [4][4];
        logic [127:0] res;
        if (!en) return d;
        coef = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
                 '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = d[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c + r) % 4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (lr) m[r][c] = t[r][c];
                else begin
                    m[r][c] = 8'h00;
                    for (int k = 0; k < 4; k++) m[r][c] ^= gmul(coef[r][k], t[k][c]);
                end
            end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = m[r][c];
        return res;
    endfunction

    // Input-side monitor: every accepted word queues its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)
            sb_q.push_back({ref_model(ip, enable, last_round), last_round});
    end

    // Output-side monitor: every delivered word is checked against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", 128'd1, 128'd0);
            end else begin
                e = sb_q.pop_front();
                $display("xfer op=%h last=%b", op, out_last);
                chk("sb_op", op, e.op);
                chk("sb_last", {127'd0, out_last}, {127'd0, e.last});
            end
        end
    end

    // Stall monitor: a word refused downstream must be held unchanged next cycle.
    logic         held_v = 1'b0;
    logic [127:0] held_op;
    logic         held_last;
    always @(negedge clk) begin
        if (held_v) begin
            chk("stall_valid", {127'd0, out_valid}, 128'd1);
            chk("stall_op", op, held_op);
            chk("stall_last", {127'd0, out_last}, {127'd0, held_last});
        end
        held_v    = rst_n && out_valid && !out_ready;
        held_op   = op;
        held_last = out_last;
    end

    task automatic drive(input logic v, input logic [127:0] d, input logic en,
                         input logic lr, input logic ordy);
        in_valid   = v;
        ip         = d;
        enable     = en;
        last_round = lr;
        out_ready  = ordy;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Starts and ends just after a rising edge.
    task automatic one_word(input string name, input logic [127:0] d, input logic en,
                            input logic lr, input logic [127:0] exp_op, input logic exp_last);
        drive(1'b1, d, en, lr, 1'b1);
        @(negedge clk);
        chk({name, "_in_ready"}, {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        chk({name, "_valid"}, {127'd0, out_valid}, 128'd1);
        chk({name, "_op"}, op, exp_op);
        chk({name, "_last"}, {127'd0, out_last}, {127'd0, exp_last});
        drive(1'b0, 128'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int cyc = 0;
        drive(1'b0, 128'h0, 1'b0, 1'b0, 1'b1);
        while ((out_valid || sb_q.size() != 0) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_queue_empty", 128'(sb_q.size()), 128'd0);
        chk("drain_out_valid", {127'd0, out_valid}, 128'd0);
    endtask

    // mode 0: out_ready toggles 1010 with in_valid held; mode 1: fully random handshakes.
    task automatic stream(input int n, input int mode);
        int sent = 0;
        int cyc  = 0;
        logic v, ordy, acc;
        while (sent < n && cyc < 400) begin
            ordy = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            v    = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive(v, rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy);
            @(negedge clk);
            acc = v && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        chk("stream_words_accepted", 128'(sent), 128'(n));
        drain();
    endtask

    initial begin
        int cnt;
        logic acc;
        logic [127:0] d;

        rst_n = 1'b0;
        drive(1'b0, 128'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_op", op, 128'h0);
        chk("rst_out_last", {127'd0, out_last}, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;

        one_word("fips_mix", FIPS_IN, 1'b1, 1'b0, FIPS_MC, 1'b0);
        one_word("fips_final", FIPS_IN, 1'b1, 1'b1, FIPS_SR, 1'b1);
        one_word("fips_bypass", FIPS_IN, 1'b0, 1'b0, FIPS_IN, 1'b0);
        one_word("fips_bypass_lr", FIPS_IN, 1'b0, 1'b1, FIPS_IN, 1'b1);
        one_word("col0", COL_IN, 1'b1, 1'b0, COL_OUT, 1'b0);
        drain();

        // Eight back-to-back words with out_ready held high: one per cycle.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, rnd128(), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            @(negedge clk);
            chk("thru_in_ready", {127'd0, in_ready}, 128'd1);
            @(posedge clk); #1;
            chk("thru_out_valid", {127'd0, out_valid}, 128'd1);
        end
        drive(1'b0, 128'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("thru_tail_empty", {127'd0, out_valid}, 128'd0);
        drain();

        stream(8, 0);

        // Stall five cycles with in_valid held: capacity words accepted, then in_ready low.
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, rnd128(), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) cnt++;
        end
        chk("stall_accepted", 128'(cnt), 128'(CAP));
        @(negedge clk);
        chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
        @(posedge clk); #1;

        // One-cycle reset while a word is stalled discards it.
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {127'd0, in_ready}, 128'd0);
        sb_q.delete();
        @(posedge clk); #1;
        chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_op", op, 128'h0);
        chk("midrst_out_last", {127'd0, out_last}, 128'd0);
        rst_n = 1'b1;
        d = rnd128();
        drive(1'b1, d, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("postrst_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        chk("postrst_out_valid", {127'd0, out_valid}, 128'd1);
        chk("postrst_op", op, ref_model(d, 1'b1, 1'b0));
        drain();

        stream(40, 1);
        stream(40, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_mix_stage.md
# shift_mix_stage

Registered ShiftRows + MixColumns stage of the AES encryption datapath, directly downstream of the 16-sbox SubBytes block. It takes the 128-bit SubBytes result, applies ShiftRows and, except in the final round, MixColumns. The result is presented to the AddRoundKey stage through a valid/ready pipeline register. Round-type and bypass control travel with the data so back-pressure never desynchronises them.

## Interface
Parameters: none; width is fixed at 128 bits, byte-sliced as in SubBytes.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset; **synchronous, active-low**
- in_valid  input  1  upstream holds a valid state word
- in_ready  output  1  stage can accept a word this cycle
- ip  input  128  state after SubBytes; ip[127:120] = byte 0 = s(0,0), column-major (byte 4c+r = s(r,c))
- last_round  input  1  sampled with ip; 1 = skip MixColumns (AES final round)
- enable  input  1  sampled with ip; 0 = pass ip through unchanged
- out_valid  output  1  op/out_last valid
- out_ready  input  1  downstream accepts
- op  output  128  transformed state, same byte ordering
- out_last  output  1  registered copy of last_round for the held word

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- ShiftRows: output byte s'(r,c) = s(r,(c+r) mod 4). Row 0 is unchanged; rows 1/2/3 rotate left by 1/2/3.
- MixColumns, per column, over GF(2^8) mod 0x11B:
  - s'0 = 2a ^ 3b ^ c ^ d
  - s'1 = a ^ 2b ^ 3c ^ d
  - s'2 = a ^ b ^ 2c ^ 3d
  - s'3 = 3a ^ b ^ c ^ 2d
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0); 3x = xtime(x) ^ x. All results are 8-bit; no carries escape.
- Result selection:
  - enable=0: op = ip (last_round ignored).
  - enable=1, last_round=1: ShiftRows only.
  - enable=1, last_round=0: ShiftRows then MixColumns.
- The transform is computed combinationally on the input side and registered. Output-side data is never recomputed.
- The held word is stable (op, out_last unchanged) while out_valid=1 and out_ready=0.
- Input-side data is never dropped and never duplicated. Words emerge in acceptance order.

## Timing
- Reset (rst_n=0 at an edge):
  - out_valid=0, op=128'h0, out_last=0, any skid entry cleared.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
- Latency: a word accepted at edge N is visible on op with out_valid=1 after edge N.
- Throughput: one word per cycle when out_ready is held at 1.
- Simultaneous in-transfer and out-transfer in the same cycle: the new word replaces the old one; out_valid stays 1.
- Reset mid-operation discards every held word. No partial output follows reset.
- out_valid must not depend combinationally on in_valid.

## Configuration
- SHIFT_MIX_SKID_EN defined:
  - Two-entry skid buffer (main + skid register).
  - in_ready is a register output (= skid entry empty) with no combinational path from out_ready.
  - When out_ready drops, one extra word is absorbed into the skid entry.
  - Full throughput is retained.
- SHIFT_MIX_SKID_EN undefined:
  - Single output register.
  - in_ready = !out_valid || out_ready (combinational).
- Latency, data transform and reset values are identical in both builds.

## Test plan
- FIPS-197 App. B round 1: ip=d42711aee0bf98f1b8b45de51e415230, enable=1, last_round=0 -> op=046681e5e0cb199a48f8d37a2806264c one cycle later, out_last=0.
- Same ip, last_round=1 -> op=d4bf5d30e0b452aeb84111f11e2798e5, out_last=1. Same ip with enable=0 -> op=ip.
- Single-column check: column 0 bytes db,13,53,45 with rows 1–3 arranged so ShiftRows puts them in column 0 -> output column 0 = 8e,4d,a1,bc.
- Back-to-back stream of 8 words:
  - out_ready=1 throughout -> 8 outputs on 8 consecutive cycles, in order.
  - out_ready toggled 1010… -> no loss or duplication, op stable while stalled.
  - With SHIFT_MIX_SKID_EN: in_ready deasserts only after 2 words are held.
- Stall with out_ready=0 for 5 cycles while in_valid=1 -> in_ready low after capacity is reached (1 word without the macro, 2 with it); the held op is unchanged each cycle.
- Assert rst_n=0 for one cycle while out_valid=1 and a word is stalled -> next cycle out_valid=0, op=0, out_last=0; a subsequent input appears after exactly 1 cycle.
